// File: rtl/store_align_pkg.sv
// ----------------------------------------------------------------------------
// store_align_pkg
//
// Shared definitions for the store-side data formatter.
//   - Store size encodings as presented by the load/store execution stage.
//   - FSM state encodings for store_align_unit (IDLE / BEAT1 / BEAT2).
//   - Big-endian lane masks: byte offset 0 lives on lanes [31:24] and maps
//     to mask bit 3, the same ordering the load-side extender uses.
//   - A packed beat record (mask + lane data) and helpers for size decoding
//     and natural-alignment checks.
//
// Optional feature macro: STORE_ALIGN_MISALIGN_SPLIT_EN (used by the top).
// ----------------------------------------------------------------------------
package store_align_pkg;

    // Store size encodings; 2'b11 is decoded as a word everywhere.
    localparam logic [1:0] STORE_SIZE_BYTE = 2'b00;
    localparam logic [1:0] STORE_SIZE_HALF = 2'b01;
    localparam logic [1:0] STORE_SIZE_WORD = 2'b10;

    // FSM state encodings.
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BEAT1 = 2'b01;
    localparam logic [1:0] ST_BEAT2 = 2'b10;

    // Left-justified lane masks: the first byte of the store always sits on
    // lane 0 (bits [31:24], mask bit 3) before the offset shift is applied.
    localparam logic [3:0] LANE_MASK_BYTE = 4'b1000;
    localparam logic [3:0] LANE_MASK_HALF = 4'b1100;
    localparam logic [3:0] LANE_MASK_WORD = 4'b1111;

    // One memory beat as produced by the lane shifter.
    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } lane_beat_t;

    // Number of bytes written by a store of the given size.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            STORE_SIZE_BYTE: size_bytes = 3'd1;
            STORE_SIZE_HALF: size_bytes = 3'd2;
            default:         size_bytes = 3'd4;
        endcase
    endfunction

    // True when the byte offset is not a multiple of the access size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            STORE_SIZE_BYTE: is_misaligned = 1'b0;
            STORE_SIZE_HALF: is_misaligned = off[0];
            default:         is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/store_lane_shift.sv
// ----------------------------------------------------------------------------
// store_lane_shift
//
// Purely combinational lane formatter. Left-justifies right-justified store
// data onto big-endian lanes, then shifts data and byte mask for the
// requested beat of a store at the given byte offset.
//
// Ports
//   off       in   2   byte offset of the store address
//   size      in   2   store size (byte / half / word, 2'b11 = word)
//   data      in  32   right-justified store data
//   second    in   1   0: first beat, 1: second beat of a crossing store
//   beat      out 36   lane-positioned data and byte-write mask
//   crossing  out  1   store spills into the next word
// ----------------------------------------------------------------------------
module store_lane_shift
    import store_align_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [31:0] data,
    input  logic        second,
    output lane_beat_t  beat,
    output logic        crossing
);

    logic [31:0] left_data;
    logic [3:0]  left_mask;
    logic [2:0]  nbytes;
    logic [2:0]  tail_shift;

    // Move the first store byte onto lane 0 so every size shifts the same way.
    always_comb begin
        case (size)
            STORE_SIZE_BYTE: begin
                left_data = {data[7:0], 24'h000000};
                left_mask = LANE_MASK_BYTE;
            end
            STORE_SIZE_HALF: begin
                left_data = {data[15:0], 16'h0000};
                left_mask = LANE_MASK_HALF;
            end
            default: begin
                left_data = data;
                left_mask = LANE_MASK_WORD;
            end
        endcase
    end

    assign nbytes     = size_bytes(size);
    assign crossing   = (({1'b0, off} + nbytes) > 3'd4);
    assign tail_shift = 3'd4 - {1'b0, off};

    // First beat shifts right by the offset; the second beat shifts the
    // spilled bytes left so they land on the low lane numbers of the next
    // word. Shifts are done at the operand width, so bits pushed out simply
    // drop off, which is exactly the truncation wanted.
    always_comb begin
        if (second) begin
            beat.data = left_data << {tail_shift, 3'b000};
            beat.mask = left_mask << tail_shift;
        end else begin
            beat.data = left_data >> {off, 3'b000};
            beat.mask = left_mask >> off;
        end
    end

endmodule

// File: rtl/store_align_unit.sv
// ----------------------------------------------------------------------------
// store_align_unit
//
// Store-side formatter between the load/store stage and the data-memory
// request port. Accepts one store per handshake, places it on big-endian
// byte lanes with a byte-write mask and issues word-aligned write beats.
//
// Build option: STORE_ALIGN_MISALIGN_SPLIT_EN
//   defined   - any offset is legal; word-crossing stores become two beats
//               (BEAT1 then BEAT2); the fault outputs are tied low.
//   undefined - stores not aligned to their size are consumed without a
//               memory beat and raise a one-cycle fault pulse.
//
// Ports
//   iCLOCK        in   1        clock, rising edge
//   inRESET       in   1        synchronous active-low reset
//   iFLUSH        in   1        drop any pending beat, return to IDLE
//   iREQ_VALID    in   1        store request present
//   oREQ_BUSY     out  1        request not accepted this cycle
//   iREQ_SIZE     in   2        byte / half / word (2'b11 = word)
//   iREQ_ADDR     in   P_ADDR_N byte address
//   iREQ_DATA     in  32        right-justified store data
//   oMEM_VALID    out  1        write beat present
//   iMEM_BUSY     in   1        memory stalling; beat held stable
//   oMEM_ADDR     out  P_ADDR_N word-aligned beat address
//   oMEM_MASK     out  4        byte enables, bit 3 = lanes [31:24]
//   oMEM_DATA     out 32        lane-positioned data, unmasked lanes zero
//   oFAULT_VALID  out  1        misaligned store rejected (pulse)
//   oFAULT_ADDR   out  P_ADDR_N address of the rejected store
// ----------------------------------------------------------------------------
module store_align_unit
    import store_align_pkg::*;
#(
    parameter int P_ADDR_N = 32
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    input  logic                iFLUSH,
    input  logic                iREQ_VALID,
    output logic                oREQ_BUSY,
    input  logic [1:0]          iREQ_SIZE,
    input  logic [P_ADDR_N-1:0] iREQ_ADDR,
    input  logic [31:0]         iREQ_DATA,
    output logic                oMEM_VALID,
    input  logic                iMEM_BUSY,
    output logic [P_ADDR_N-1:0] oMEM_ADDR,
    output logic [3:0]          oMEM_MASK,
    output logic [31:0]         oMEM_DATA,
    output logic                oFAULT_VALID,
    output logic [P_ADDR_N-1:0] oFAULT_ADDR
);

    logic [1:0]          state, state_n;
    logic [P_ADDR_N-1:0] mem_addr, mem_addr_n;
    logic [3:0]          mem_mask, mem_mask_n;
    logic [31:0]         mem_data, mem_data_n;

    logic                req_busy;
    logic                accept;

    logic [1:0]          shift_off;
    logic [1:0]          shift_size;
    logic [31:0]         shift_data;
    logic                shift_second;
    lane_beat_t          shift_beat;
    logic                shift_cross;

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    // The accepted request is kept so its spilled bytes can be formatted
    // while beat 1 is on the bus.
    logic [1:0]          pend_off, pend_off_n;
    logic [1:0]          pend_size, pend_size_n;
    logic [31:0]         pend_data, pend_data_n;
    logic                pend_cross, pend_cross_n;
    logic                second_due;

    // While beat 1 of a crossing store is outstanding no new request can be
    // taken, so the single shifter is free to format beat 2 instead.
    assign second_due   = (state == ST_BEAT1) && pend_cross;
    assign shift_second = second_due;
    assign shift_off    = second_due ? pend_off  : iREQ_ADDR[1:0];
    assign shift_size   = second_due ? pend_size : iREQ_SIZE;
    assign shift_data   = second_due ? pend_data : iREQ_DATA;

    assign req_busy = iFLUSH
                   || ((state != ST_IDLE) && (iMEM_BUSY || second_due));
`else
    logic                fault_valid, fault_valid_n;
    logic [P_ADDR_N-1:0] fault_addr, fault_addr_n;
    logic                reject;

    assign shift_second = 1'b0;
    assign shift_off    = iREQ_ADDR[1:0];
    assign shift_size   = iREQ_SIZE;
    assign shift_data   = iREQ_DATA;

    // An aligned store never crosses; the crossing term also catches any
    // store that would need a second beat, which this build cannot issue.
    assign reject   = is_misaligned(iREQ_SIZE, iREQ_ADDR[1:0]) || shift_cross;
    assign req_busy = iFLUSH || ((state != ST_IDLE) && iMEM_BUSY);
`endif

    assign accept = iREQ_VALID && !req_busy;

    store_lane_shift u_lane_shift (
        .off      (shift_off),
        .size     (shift_size),
        .data     (shift_data),
        .second   (shift_second),
        .beat     (shift_beat),
        .crossing (shift_cross)
    );

    // Next-state and next-beat selection. Priority: pending second beat,
    // then (rejected or) accepted request, then plain retirement of the
    // beat on the bus. A retiring final beat and a new accept share one edge.
    always_comb begin
        state_n    = state;
        mem_addr_n = mem_addr;
        mem_mask_n = mem_mask;
        mem_data_n = mem_data;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        pend_off_n   = pend_off;
        pend_size_n  = pend_size;
        pend_data_n  = pend_data;
        pend_cross_n = pend_cross;

        if (second_due) begin
            if (!iMEM_BUSY) begin
                state_n      = ST_BEAT2;
                mem_addr_n   = mem_addr + P_ADDR_N'(4);
                mem_mask_n   = shift_beat.mask;
                mem_data_n   = shift_beat.data;
                pend_cross_n = 1'b0;
            end
        end else
`else
        fault_valid_n = 1'b0;
        fault_addr_n  = fault_addr;

        if (accept && reject) begin
            state_n       = ST_IDLE;
            mem_addr_n    = '0;
            mem_mask_n    = '0;
            mem_data_n    = '0;
            fault_valid_n = 1'b1;
            fault_addr_n  = iREQ_ADDR;
        end else
`endif
        if (accept) begin
            state_n    = ST_BEAT1;
            mem_addr_n = {iREQ_ADDR[P_ADDR_N-1:2], 2'b00};
            mem_mask_n = shift_beat.mask;
            mem_data_n = shift_beat.data;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
            pend_off_n   = iREQ_ADDR[1:0];
            pend_size_n  = iREQ_SIZE;
            pend_data_n  = iREQ_DATA;
            pend_cross_n = shift_cross;
`endif
        end else if ((state != ST_IDLE) && !iMEM_BUSY) begin
            state_n    = ST_IDLE;
            mem_addr_n = '0;
            mem_mask_n = '0;
            mem_data_n = '0;
        end
    end

    // State and output registers; flush clears everything like reset does.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET || iFLUSH) begin
            state    <= ST_IDLE;
            mem_addr <= '0;
            mem_mask <= '0;
            mem_data <= '0;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
            pend_off   <= '0;
            pend_size  <= '0;
            pend_data  <= '0;
            pend_cross <= 1'b0;
`else
            fault_valid <= 1'b0;
            fault_addr  <= '0;
`endif
        end else begin
            state    <= state_n;
            mem_addr <= mem_addr_n;
            mem_mask <= mem_mask_n;
            mem_data <= mem_data_n;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
            pend_off   <= pend_off_n;
            pend_size  <= pend_size_n;
            pend_data  <= pend_data_n;
            pend_cross <= pend_cross_n;
`else
            fault_valid <= fault_valid_n;
            fault_addr  <= fault_addr_n;
`endif
        end
    end

    assign oREQ_BUSY  = req_busy;
    assign oMEM_VALID = (state != ST_IDLE);
    assign oMEM_ADDR  = mem_addr;
    assign oMEM_MASK  = mem_mask;
    assign oMEM_DATA  = mem_data;

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    assign oFAULT_VALID = 1'b0;
    assign oFAULT_ADDR  = '0;
`else
    assign oFAULT_VALID = fault_valid;
    assign oFAULT_ADDR  = fault_addr;
`endif

endmodule

// File: tb/tb_store_align_unit.sv
// ----------------------------------------------------------------------------
// tb_store_align_unit
//
// Self-checking bench for store_align_unit. Directed cases cover reset,
// aligned stores, misaligned handling (split or fault, depending on
// STORE_ALIGN_MISALIGN_SPLIT_EN), backpressure, back-to-back issue and
// flush. A randomized run compares every cycle against a byte-by-byte
// reference model: each store byte is routed to its own address, and the
// expected beats are the words those addresses fall in.
// ----------------------------------------------------------------------------
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_busy;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        mem_valid;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data;
    logic        fault_valid;
    logic [31:0] fault_addr;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    store_align_unit #(.P_ADDR_N(32)) dut (
        .iCLOCK       (clk),
        .inRESET      (rst_n),
        .iFLUSH       (flush),
        .iREQ_VALID   (req_valid),
        .oREQ_BUSY    (req_busy),
        .iREQ_SIZE    (req_size),
        .iREQ_ADDR    (req_addr),
        .iREQ_DATA    (req_data),
        .oMEM_VALID   (mem_valid),
        .iMEM_BUSY    (mem_busy),
        .oMEM_ADDR    (mem_addr),
        .oMEM_MASK    (mem_mask),
        .oMEM_DATA    (mem_data),
        .oFAULT_VALID (fault_valid),
        .oFAULT_ADDR  (fault_addr)
    );

    always #5 clk = ~clk;

    // Reference model: byte count for a size code.
    function automatic int store_bytes(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Reference model: whether the store is refused.
    function automatic bit model_rejects(input logic [1:0] size, input logic [31:0] addr);
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        return 1'b0;
`else
        return (int'(addr[1:0]) % store_bytes(size)) != 0;
`endif
    endfunction

    // Reference model: scatter the store bytes (most significant first) to
    // consecutive addresses and queue one beat per word touched.
    task automatic model_push(input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] data);
        int          n;
        int          w;
        int          lane;
        logic [31:0] byte_addr;
        logic [7:0]  byte_val;
        beat_t       b[2];
        n = store_bytes(size);
        b[0].addr = {addr[31:2], 2'b00};
        b[1].addr = b[0].addr + 32'd4;
        for (int k = 0; k < 2; k++) begin
            b[k].mask = 4'b0000;
            b[k].data = 32'h0;
        end
        for (int i = 0; i < n; i++) begin
            byte_addr = addr + 32'(i);
            byte_val  = 8'(data >> (8 * (n - 1 - i)));
            w         = (byte_addr[31:2] == addr[31:2]) ? 0 : 1;
            lane      = int'(byte_addr[1:0]);
            b[w].mask[3 - lane] = 1'b1;
            b[w].data[8 * (3 - lane) +: 8] = byte_val;
        end
        exp_q.push_back(b[0]);
        if (b[1].mask != 4'b0000) exp_q.push_back(b[1]);
    endtask

    task automatic drive_req(input logic valid, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] data);
        req_valid = valid;
        req_size  = size;
        req_addr  = addr;
        req_data  = data;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive_req(1'b1, 2'b10, 32'h0000_1000, 32'h1234_5678);
        @(negedge clk);
        @(negedge clk);
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %0b want 0", mem_valid); end
        tests_run++;
        if (mem_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_addr got %h want 0", mem_addr); end
        tests_run++;
        if (mem_mask !== 4'h0) begin tests_failed++; $display("[TB] FAIL reset_mask got %b want 0000", mem_mask); end
        tests_run++;
        if (mem_data !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_data got %h want 0", mem_data); end
        tests_run++;
        if (fault_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_fault got %0b want 0", fault_valid); end
        tests_run++;
        if (fault_addr !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_fault_addr got %h want 0", fault_addr); end
        tests_run++;
        if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %0b want 0", req_busy); end
        @(negedge clk);
    endtask

    // Drive one request for a cycle and check the single resulting beat.
    task automatic test_aligned;
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        logic [3:0]  emask [3];
        logic [31:0] edata [3];
        sizes = '{2'b10, 2'b00, 2'b01};
        addrs = '{32'h0000_1000, 32'h0000_1003, 32'h0000_1002};
        datas = '{32'hAABB_CCDD, 32'h0000_00EE, 32'h0000_1234};
        emask = '{4'b1111, 4'b0001, 4'b0011};
        edata = '{32'hAABB_CCDD, 32'h0000_00EE, 32'h0000_1234};
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, sizes[i], addrs[i], datas[i]);
            #1;
            tests_run++;
            if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL aligned_busy[%0d] got %0b want 0", i, req_busy); end
            @(negedge clk);
            drive_req(1'b0, 2'b00, 32'h0, 32'h0);
            tests_run++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_mask !== emask[i] || mem_data !== edata[i]) begin
                tests_failed++;
                $display("[TB] FAIL aligned_beat[%0d] got v=%0b a=%h m=%b d=%h want v=1 a=00001000 m=%b d=%h",
                         i, mem_valid, mem_addr, mem_mask, mem_data, emask[i], edata[i]);
            end
            @(negedge clk);
            tests_run++;
            if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL aligned_retire[%0d] got %0b want 0", i, mem_valid); end
        end
    endtask

`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
    task automatic test_misaligned;
        drive_req(1'b1, 2'b10, 32'h0000_1001, 32'h1122_3344);
        @(negedge clk);
        drive_req(1'b1, 2'b10, 32'h0000_5000, 32'h5555_AAAA);
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_mask !== 4'b0111 || mem_data !== 32'h0011_2233) begin
            tests_failed++;
            $display("[TB] FAIL split_beat1 got v=%0b a=%h m=%b d=%h want v=1 a=00001000 m=0111 d=00112233", mem_valid, mem_addr, mem_mask, mem_data);
        end
        tests_run++;
        if (req_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL split_busy_beat1 got %0b want 1", req_busy); end
        @(negedge clk);
        #1;
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1004 || mem_mask !== 4'b1000 || mem_data !== 32'h4400_0000) begin
            tests_failed++;
            $display("[TB] FAIL split_beat2 got v=%0b a=%h m=%b d=%h want v=1 a=00001004 m=1000 d=44000000", mem_valid, mem_addr, mem_mask, mem_data);
        end
        tests_run++;
        if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL split_busy_beat2 got %0b want 0", req_busy); end
        @(negedge clk);
        drive_req(1'b1, 2'b10, 32'hFFFF_FFFE, 32'hA1B2_C3D4);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_5000 || mem_mask !== 4'b1111 || mem_data !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL split_next got v=%0b a=%h m=%b d=%h want v=1 a=00005000 m=1111 d=5555aaaa", mem_valid, mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        tests_run++;
        if (mem_addr !== 32'hFFFF_FFFC || mem_mask !== 4'b0011 || mem_data !== 32'h0000_A1B2) begin
            tests_failed++;
            $display("[TB] FAIL wrap_beat1 got a=%h m=%b d=%h want a=fffffffc m=0011 d=0000a1b2", mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0000 || mem_mask !== 4'b1100 || mem_data !== 32'hC3D4_0000) begin
            tests_failed++;
            $display("[TB] FAIL wrap_beat2 got v=%0b a=%h m=%b d=%h want v=1 a=00000000 m=1100 d=c3d40000", mem_valid, mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_retire got %0b want 0", mem_valid); end
    endtask
`else
    task automatic test_misaligned;
        drive_req(1'b1, 2'b01, 32'h0000_2001, 32'h0000_BEEF);
        @(negedge clk);
        drive_req(1'b1, 2'b10, 32'h0000_2004, 32'h0BAD_CAFE);
        #1;
        tests_run++;
        if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_no_beat got %0b want 0", mem_valid); end
        tests_run++;
        if (fault_valid !== 1'b1 || fault_addr !== 32'h0000_2001) begin
            tests_failed++;
            $display("[TB] FAIL fault_pulse got v=%0b a=%h want v=1 a=00002001", fault_valid, fault_addr);
        end
        tests_run++;
        if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_next_busy got %0b want 0", req_busy); end
        @(negedge clk);
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        tests_run++;
        if (fault_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fault_one_cycle got %0b want 0", fault_valid); end
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_2004 || mem_mask !== 4'b1111 || mem_data !== 32'h0BAD_CAFE) begin
            tests_failed++;
            $display("[TB] FAIL fault_then_aligned got v=%0b a=%h m=%b d=%h want v=1 a=00002004 m=1111 d=0badcafe", mem_valid, mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_backpressure;
        drive_req(1'b1, 2'b10, 32'h0000_3000, 32'hDEAD_BEEF);
        @(negedge clk);
        mem_busy = 1'b1;
        drive_req(1'b1, 2'b01, 32'h0000_3006, 32'h0000_BEEF);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (req_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_busy[%0d] got %0b want 1", k, req_busy); end
            tests_run++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_3000 || mem_mask !== 4'b1111 || mem_data !== 32'hDEAD_BEEF) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold[%0d] got v=%0b a=%h m=%b d=%h want v=1 a=00003000 m=1111 d=deadbeef", k, mem_valid, mem_addr, mem_mask, mem_data);
            end
            @(negedge clk);
        end
        mem_busy = 1'b0;
        #1;
        tests_run++;
        if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_busy got %0b want 0", req_busy); end
        @(negedge clk);
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        tests_run++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_3004 || mem_mask !== 4'b0011 || mem_data !== 32'h0000_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL bp_next got v=%0b a=%h m=%b d=%h want v=1 a=00003004 m=0011 d=0000beef", mem_valid, mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
    endtask

    // Aligned random stores one per cycle; each must appear the next cycle.
    task automatic test_back_to_back;
        logic [1:0]  size;
        logic [31:0] addr;
        beat_t       b;
        for (int i = 0; i < 8; i++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            addr = addr & ~(32'(store_bytes(size)) - 32'd1);
            drive_req(1'b1, size, addr, $urandom);
            model_push(size, addr, req_data);
            #1;
            tests_run++;
            if (req_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_busy[%0d] got %0b want 0", i, req_busy); end
            @(negedge clk);
            b = exp_q.pop_front();
            tests_run++;
            if (mem_valid !== 1'b1 || mem_addr !== b.addr || mem_mask !== b.mask || mem_data !== b.data) begin
                tests_failed++;
                $display("[TB] FAIL b2b_beat[%0d] got v=%0b a=%h m=%b d=%h want v=1 a=%h m=%b d=%h",
                         i, mem_valid, mem_addr, mem_mask, mem_data, b.addr, b.mask, b.data);
            end
        end
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_drain got %0b want 0", mem_valid); end
        exp_q.delete();
    endtask

    task automatic test_flush;
`ifdef STORE_ALIGN_MISALIGN_SPLIT_EN
        drive_req(1'b1, 2'b10, 32'h0000_1003, 32'hCAFE_F00D);
`else
        drive_req(1'b1, 2'b10, 32'h0000_1004, 32'hCAFE_F00D);
`endif
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_pre_valid got %0b want 1", mem_valid); end
        flush = 1'b1;
        mem_busy = 1'b1;
        drive_req(1'b1, 2'b10, 32'h0000_6000, 32'h6666_6666);
        #1;
        tests_run++;
        if (req_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_busy got %0b want 1", req_busy); end
        @(negedge clk);
        flush = 1'b0;
        mem_busy = 1'b0;
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        tests_run++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_mask !== 4'h0 || mem_data !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL flush_clear got v=%0b a=%h m=%b d=%h want all 0", mem_valid, mem_addr, mem_mask, mem_data);
        end
        @(negedge clk);
        tests_run++;
        if (mem_valid !== 1'b0 || fault_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_beat got v=%0b f=%0b want 0 0", mem_valid, fault_valid);
        end
    endtask

    // Random traffic with random backpressure, checked every cycle.
    task automatic test_random;
        bit          fault_exp;
        logic [31:0] fault_addr_exp;
        bit          exp_busy;
        exp_q.delete();
        fault_exp = 1'b0;
        fault_addr_exp = 32'h0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            tests_run++;
            if (mem_valid !== (exp_q.size() > 0)) begin
                tests_failed++;
                $display("[TB] FAIL rnd_valid cyc %0d got %0b want %0b", cyc, mem_valid, exp_q.size() > 0);
            end else if (exp_q.size() > 0) begin
                tests_run++;
                if (mem_addr !== exp_q[0].addr || mem_mask !== exp_q[0].mask || mem_data !== exp_q[0].data) begin
                    tests_failed++;
                    $display("[TB] FAIL rnd_beat cyc %0d got a=%h m=%b d=%h want a=%h m=%b d=%h",
                             cyc, mem_addr, mem_mask, mem_data, exp_q[0].addr, exp_q[0].mask, exp_q[0].data);
                end
            end
            tests_run++;
            if (fault_valid !== fault_exp || (fault_exp && fault_addr !== fault_addr_exp)) begin
                tests_failed++;
                $display("[TB] FAIL rnd_fault cyc %0d got v=%0b a=%h want v=%0b a=%h",
                         cyc, fault_valid, fault_addr, fault_exp, fault_addr_exp);
            end
            mem_busy = ($urandom_range(0, 3) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_size = 2'($urandom_range(0, 3));
            req_addr = $urandom;
            if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) req_addr[31:2] = '1;
            req_data = $urandom;
            #1;
            exp_busy = (exp_q.size() > 0) && (mem_busy || exp_q.size() > 1);
            tests_run++;
            if (req_busy !== exp_busy) begin
                tests_failed++;
                $display("[TB] FAIL rnd_busy cyc %0d got %0b want %0b", cyc, req_busy, exp_busy);
            end
            fault_exp = 1'b0;
            if (exp_q.size() > 0 && !mem_busy) void'(exp_q.pop_front());
            if (req_valid && !exp_busy) begin
                if (model_rejects(req_size, req_addr)) begin
                    fault_exp = 1'b1;
                    fault_addr_exp = req_addr;
                end else begin
                    model_push(req_size, req_addr, req_data);
                end
            end
            @(negedge clk);
        end
        drive_req(1'b0, 2'b00, 32'h0, 32'h0);
        mem_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_misaligned();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/store_align_unit.md
# store_align_unit

Store-side data formatter between the load/store execution stage and the data-memory request port. Accepts one store request per handshake (byte, halfword or word at any byte address), positions the data onto the correct big-endian byte lanes of a 32-bit bus, generates the byte-write mask, and issues a word-aligned memory write. Stores that cross a word boundary are split into two memory beats by a small state machine. Misaligned stores are rejected when splitting is not compiled in.

## Interface
- P_ADDR_N, 32, address width; bits [1:0] are the byte offset.
- iCLOCK  in  1  clock; all state updates on its rising edge.
- inRESET  in  1  synchronous, active-low reset.
- iFLUSH  in  1  discards any pending beat and returns to IDLE next edge; has priority over all handshakes.
- iREQ_VALID  in  1  store request present.
- oREQ_BUSY  out  1  request not accepted this cycle.
- iREQ_SIZE  in  2  2'b00 byte, 2'b01 halfword, 2'b10 word; 2'b11 is treated as word.
- iREQ_ADDR  in  P_ADDR_N  byte address.
- iREQ_DATA  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- oMEM_VALID  out  1  memory write beat present.
- iMEM_BUSY  in  1  memory not accepting; the beat is held stable.
- oMEM_ADDR  out  P_ADDR_N  word-aligned address ([1:0] = 2'b00).
- oMEM_MASK  out  4  byte-write enables; bit 3 = lanes [31:24] = byte offset 0.
- oMEM_DATA  out  32  lane-positioned data; unmasked lanes drive 0.
- oFAULT_VALID  out  1  one-cycle pulse: misaligned store rejected.
- oFAULT_ADDR  out  P_ADDR_N  offending byte address, valid with oFAULT_VALID.

## Operation
- Request accepted when iREQ_VALID && !oREQ_BUSY.
- Left-justify: byte {d[7:0],24'h0}, mask 4'b1000; half {d[15:0],16'h0}, mask 4'b1100; word d, mask 4'b1111. off = addr[1:0].
- Beat 1: addr = {addr[P_ADDR_N-1:2],2'b00}, data = L >> (8*off), mask = M >> off.
- Crossing when (off + bytes) > 4. Beat 2: addr = beat-1 addr + 4 (wraps modulo 2^P_ADDR_N), data = L << (8*(4-off)), mask = (M << (4-off)) truncated to 4 bits.
- States: IDLE (output empty), BEAT1 (beat 1 on output), BEAT2 (beat 2 on output).
  - IDLE: accept -> BEAT1; fault -> stay IDLE.
  - BEAT1: if !iMEM_BUSY: crossing -> BEAT2; else if new request accepted -> BEAT1 (new beat); else IDLE.
  - BEAT2: if !iMEM_BUSY: new request accepted -> BEAT1; else IDLE.
- oREQ_BUSY = (state != IDLE) && (iMEM_BUSY || (state == BEAT1 && crossing)).
- Simultaneous final-beat accept and new request: both occur the same edge; no bubble.
- iFLUSH while iREQ_VALID: the request is not accepted; oREQ_BUSY reads 1 during flush.

## Timing
- Reset and flush values: state IDLE; oMEM_VALID 0; oMEM_ADDR, oMEM_MASK, oMEM_DATA 0; oFAULT_VALID 0; oFAULT_ADDR 0; oREQ_BUSY 0 after reset (1 during the flush cycle).
- Latency: request accepted at edge N -> oMEM_VALID high from N+1. Second beat appears the cycle after beat 1 is accepted.
- Outputs are registered. oREQ_BUSY is combinational from state and iMEM_BUSY.
- Once oMEM_VALID is asserted, beat contents are held stable until accepted or flushed.
- Throughput: one aligned store per cycle with iMEM_BUSY low. A crossing store occupies two cycles.

## Configuration
- STORE_ALIGN_MISALIGN_SPLIT_EN defined: any byte offset is legal. Crossing stores split as above. oFAULT_VALID is tied 0.
- Not defined: a request with addr not a multiple of its size (half with addr[0]=1; word with addr[1:0]!=0) is consumed, issues no memory beat, and pulses oFAULT_VALID for one cycle at N+1 with oFAULT_ADDR = request address. BEAT2 is not implemented.

## Structure
- Shared core package/header:
  - size encodings STORE_SIZE_BYTE/HALF/WORD
  - state encodings for IDLE/BEAT1/BEAT2
  - lane-order constants, matching the load-side extender's big-endian convention
- One combinational sub-module, store_lane_shift: left-justification, mask and shift for a given offset, size and beat number. The FSM and registers live in store_align_unit.

## Test plan
- Aligned word: addr 0x1000, data 0xAABBCCDD, iMEM_BUSY 0 -> one beat next cycle: addr 0x1000, mask 4'b1111, data 0xAABBCCDD.
- Byte at 0x1003, data 0x000000EE -> addr 0x1000, mask 4'b0001, data 0x000000EE. Half at 0x1002, data 0x00001234 -> mask 4'b0011, data 0x00001234.
- With _EN: word at 0x1001, data 0x11223344 -> beat 1: addr 0x1000, mask 4'b0111, data 0x00112233; beat 2: addr 0x1004, mask 4'b1000, data 0x44000000. oREQ_BUSY is high during beat 1.
- Without _EN: half at 0x2001 -> no oMEM_VALID; oFAULT_VALID pulses one cycle with oFAULT_ADDR 0x2001. The next aligned request is accepted the following cycle.
- Backpressure: iMEM_BUSY high for 3 cycles with a beat pending -> oMEM_* stable and oREQ_BUSY high throughout. Back-to-back requests are then accepted one per cycle with no bubble.
- Wrap and flush:
  - Word at 0xFFFFFFFE (_EN) -> beat 2 addr 0x00000000, mask 4'b1100.
  - iFLUSH asserted during BEAT1 of a crossing store -> next cycle oMEM_VALID 0, state IDLE, no beat 2.
